fpu_div: RTL and testbench

Sequential IEEE-754 single-precision divider, the inverse datapath of `fpu_mul`, used by the FFT datapath wherever a normalising or scaling division is needed. Accepts one operand pair through a valid/ready handshake and computes the mantissa quotient with a radix-2 restoring iteration. Rounds to nearest-even and presents the result through a held valid/ready output. Numeric conventions match `fpu_mul`: flush-to-zero and a canonical NaN.

---
 rtl/fpu_pkg.sv | 22 ++
 rtl/fpu_classify.sv | 23 ++
 rtl/fpu_div.sv | 179 +++++++++++++++++
 tb/tb_fpu_div.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared single-precision constants, flag positions and divider state encoding
// used by the fpu_* datapath blocks.
package fpu_pkg;

    localparam int SIZE_EXP = 8;
    localparam int SIZE_MAN = 23;
    localparam int EXP_BIAS = 127;
    localparam logic [31:0] QNAN = 32'h7fc00000;

    localparam int FLAG_NV = 3;
    localparam int FLAG_DZ = 2;
    localparam int FLAG_OF = 1;
    localparam int FLAG_UF = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV   = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } div_state_t;

endpackage

// File: rtl/fpu_classify.sv
// Combinational operand classifier: unpacks one single-precision word and
// tags it as zero (FTZ), infinity or NaN.
module fpu_classify
    import fpu_pkg::*;
(
    input  logic [31:0]         operand,
    output logic                sign,
    output logic [SIZE_EXP-1:0] expo,
    output logic [SIZE_MAN-1:0] man,
    output logic                is_zero,
    output logic                is_inf,
    output logic                is_nan
);

    assign sign    = operand[31];
    assign expo    = operand[30:23];
    assign man     = operand[22:0];
    // Any zero exponent is zero, subnormal mantissas are flushed.
    assign is_zero = (expo == '0);
    assign is_inf  = (expo == '1) && (man == '0);
    assign is_nan  = (expo == '1) && (man != '0);

endmodule

// File: rtl/fpu_div.sv
// Sequential single-precision divider: radix-2 restoring mantissa division,
// one quotient bit per cycle, round-to-nearest-even, FTZ, canonical NaN.
module fpu_div
    import fpu_pkg::*;
#(
    parameter int SIZE_DATA = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [SIZE_DATA-1:0] i_32_a,
    input  logic [SIZE_DATA-1:0] i_32_b,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [SIZE_DATA-1:0] o_32_div,
    output logic [3:0]           o_flags
);

    logic                a_sign, b_sign;
    logic [SIZE_EXP-1:0] a_exp, b_exp;
    logic [SIZE_MAN-1:0] a_man, b_man;
    logic                a_zero, a_inf, a_nan;
    logic                b_zero, b_inf, b_nan;

    fpu_classify u_class_a (
        .operand (i_32_a),
        .sign    (a_sign),
        .expo    (a_exp),
        .man     (a_man),
        .is_zero (a_zero),
        .is_inf  (a_inf),
        .is_nan  (a_nan)
    );

    fpu_classify u_class_b (
        .operand (i_32_b),
        .sign    (b_sign),
        .expo    (b_exp),
        .man     (b_man),
        .is_zero (b_zero),
        .is_inf  (b_inf),
        .is_nan  (b_nan)
    );

    div_state_t          state, state_nxt;
    logic [4:0]          cnt;
    logic [24:0]         rem;
    logic [23:0]         divisor;
    logic [25:0]         quo;
    logic                sign_q;
    logic signed [9:0]   exp_base;

    logic                accept;
    logic                res_sign;
    logic                special;
    logic [31:0]         spec_res;
    logic [3:0]          spec_flags;
    logic [24:0]         diff;
    logic                q_bit;

    assign o_ready  = (state == IDLE);
    assign accept   = i_valid & o_ready;
    assign res_sign = a_sign ^ b_sign;

    // Special-operand priority: NaN-producing cases first, then inf dividend,
    // then zero divisor, then zero quotient.
    always_comb begin
        special    = 1'b1;
        spec_res   = '0;
        spec_flags = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res            = QNAN;
            spec_flags[FLAG_NV] = 1'b1;
        end else if (a_inf) begin
            spec_res = {res_sign, 8'hff, 23'd0};
        end else if (b_zero) begin
            spec_res            = {res_sign, 8'hff, 23'd0};
            spec_flags[FLAG_DZ] = 1'b1;
        end else if (a_zero || b_inf) begin
            spec_res = {res_sign, 31'd0};
        end else begin
            special = 1'b0;
        end
    end

    assign diff  = rem - {1'b0, divisor};
    assign q_bit = (rem >= {1'b0, divisor});

    function automatic logic [35:0] round_rne(
        input logic [25:0]       q,
        input logic              sticky,
        input logic              sgn,
        input logic signed [9:0] eb
    );
        logic [23:0]       sig;
        logic              guard;
        logic              inc;
        logic [24:0]       sum;
        logic signed [9:0] e;
        logic [31:0]       res;
        logic [3:0]        fl;
        if (q[25]) begin
            sig   = q[25:2];
            guard = q[1];
            e     = eb;
        end else begin
            sig   = q[24:1];
            guard = q[0];
            e     = eb - 10'sd1;
        end
        inc = guard & (sticky | sig[0]);
        sum = {1'b0, sig} + {24'd0, inc};
        if (sum[24])
            e = e + 10'sd1;
        fl = '0;
        if (e >= 10'sd255) begin
            res         = {sgn, 8'hff, 23'd0};
            fl[FLAG_OF] = 1'b1;
        end else if (e <= 10'sd0) begin
            res         = {sgn, 31'd0};
            fl[FLAG_UF] = 1'b1;
        end else begin
            res = {sgn, e[7:0], (sum[24] ? sum[23:1] : sum[22:0])};
        end
        return {fl, res};
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = special ? DONE : DIV;
            DIV:     if (cnt == 5'd0) state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    if (o_valid && i_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            o_valid  <= 1'b0;
            o_32_div <= '0;
            o_flags  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    cnt <= 5'd25;
                    if (accept && special) begin
                        o_32_div <= spec_res;
                        o_flags  <= spec_flags;
                    end
                end
                DIV:   cnt <= cnt - 5'd1;
                ROUND: {o_flags, o_32_div} <= round_rne(quo, (rem != '0), sign_q, exp_base);
                DONE:  o_valid <= ~(o_valid & i_ready);
                default: ;
            endcase
        end
    end

    // Division datapath: operands latched at accept, then one restoring step per DIV cycle.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            rem      <= {1'b0, 1'b1, a_man};
            divisor  <= {1'b1, b_man};
            quo      <= '0;
            sign_q   <= res_sign;
            exp_base <= $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + 10'sd127;
        end else if (state == DIV) begin
            rem <= q_bit ? {diff[23:0], 1'b0} : {rem[23:0], 1'b0};
            quo <= {quo[24:0], q_bit};
        end
    end

endmodule

// File: tb/tb_fpu_div.sv
// Directed plus randomized bench for fpu_div against an arithmetic reference
// model built from integer division and explicit rounding rules.
module tb_fpu_div;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_32_a;
    logic [31:0] i_32_b;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_32_div;
    logic [3:0]  o_flags;

    int tests = 0;
    int fails = 0;

    fpu_div #(.SIZE_DATA(32)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_32_a   (i_32_a),
        .i_32_b   (i_32_b),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_32_div (o_32_div),
        .o_flags  (o_flags)
    );

    initial forever #5 i_clk = ~i_clk;

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Returns {special, flags[3:0], result[31:0]}.
    function automatic logic [36:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        int unsigned ea, eb, fa, fb;
        bit s, az, ai, an, bz, bi, bn, guard, sticky;
        longint num, q, r, sig;
        int e;
        logic [31:0] res;
        ea = a[30:23]; fa = a[22:0];
        eb = b[30:23]; fb = b[22:0];
        s  = a[31] ^ b[31];
        az = (ea == 0); ai = (ea == 255 && fa == 0); an = (ea == 255 && fa != 0);
        bz = (eb == 0); bi = (eb == 255 && fb == 0); bn = (eb == 255 && fb != 0);
        if (an || bn || (az && bz) || (ai && bi)) return {1'b1, 4'b1000, 32'h7fc00000};
        if (ai) return {1'b1, 4'b0000, s, 31'h7f800000};
        if (bz) return {1'b1, 4'b0100, s, 31'h7f800000};
        if (az || bi) return {1'b1, 4'b0000, s, 31'h0};
        num = longint'(fa + 32'h800000) * 64'd33554432;
        q   = num / longint'(fb + 32'h800000);
        r   = num % longint'(fb + 32'h800000);
        e   = int'(ea) - int'(eb) + 127;
        if (q >= 64'd33554432) begin
            sig = q / 4; guard = ((q / 2) % 2) == 1;
        end else begin
            sig = q / 2; guard = (q % 2) == 1; e = e - 1;
        end
        sticky = (r != 0);
        if (guard && (sticky || (sig % 2) == 1)) sig = sig + 1;
        if (sig >= 64'd16777216) begin
            sig = sig / 2; e = e + 1;
        end
        if (e >= 255) return {1'b0, 4'b0010, s, 31'h7f800000};
        if (e <= 0) return {1'b0, 4'b0001, s, 31'h0};
        res = {s, 8'(e), 23'(sig % 64'd8388608)};
        return {1'b0, 4'b0000, res};
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic [3:0] exp_fl,
                          input int exp_lat, input bit hold);
        int w;
        int lat;
        logic [31:0] r0;
        logic [3:0]  f0;
        w = 0;
        while (!o_ready && w < 100) begin @(negedge i_clk); w++; end
        i_32_a  = a;
        i_32_b  = b;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 60) begin
            i_32_a = $urandom;
            i_32_b = $urandom;
            @(posedge i_clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_res"}, 64'(o_32_div), 64'(exp_res));
        check({tag, "_flags"}, 64'(o_flags), 64'(exp_fl));
        if (hold) begin
            r0 = o_32_div;
            f0 = o_flags;
            for (int k = 0; k < 5; k++) begin
                @(posedge i_clk);
                #1;
                check({tag, "_hold"}, {26'd0, o_valid, o_ready, o_flags, o_32_div},
                      {26'd0, 1'b1, 1'b0, f0, r0});
            end
        end
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        check({tag, "_release"}, {62'd0, o_valid, o_ready}, {62'd0, 1'b0, 1'b1});
    endtask

    task automatic run_model(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [36:0] m;
        m = ref_div(a, b);
        run_op(tag, a, b, m[31:0], m[35:32], m[36] ? 1 : 28, 1'b0);
    endtask

    initial begin
        bit          seen_valid;
        logic [31:0] ra, rb;
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_32_a  = '0;
        i_32_b  = '0;
        repeat (3) @(posedge i_clk);
        #1;
        check("reset_out", {26'd0, o_valid, o_ready, o_flags, o_32_div}, {26'd0, 1'b0, 1'b1, 4'h0, 32'h0});
        @(negedge i_clk);
        i_rst = 1'b0;

        run_op("one_div_one", 32'h3f800000, 32'h3f800000, 32'h3f800000, 4'h0, 28, 1'b0);
        run_op("three_div_two", 32'h40400000, 32'h40000000, 32'h3fc00000, 4'h0, 28, 1'b1);
        run_op("one_third", 32'h3f800000, 32'h40400000, 32'h3eaaaaab, 4'h0, 28, 1'b0);
        run_op("neg_five_half", 32'hc0a00000, 32'h40000000, 32'hc0200000, 4'h0, 28, 1'b0);
        run_op("div_zero", 32'h40a00000, 32'h00000000, 32'h7f800000, 4'b0100, 1, 1'b1);
        run_op("zero_zero", 32'h00000000, 32'h80000000, 32'h7fc00000, 4'b1000, 1, 1'b0);
        run_op("nan_in", 32'h7f800001, 32'h3f800000, 32'h7fc00000, 4'b1000, 1, 1'b0);
        run_op("inf_fin", 32'hff800000, 32'h40000000, 32'hff800000, 4'b0000, 1, 1'b0);
        run_op("fin_inf", 32'h40000000, 32'hff800000, 32'h80000000, 4'b0000, 1, 1'b0);
        run_op("overflow", 32'h7f7fffff, 32'h3f000000, 32'h7f800000, 4'b0010, 28, 1'b0);
        run_op("underflow", 32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 28, 1'b0);
        run_op("ftz_in", 32'h007fffff, 32'h3f800000, 32'h00000000, 4'b0000, 1, 1'b0);

        // Reset in the middle of a division discards it.
        i_32_a  = 32'h40400000;
        i_32_b  = 32'h3f800000;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (10) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        check("mid_reset_ready", {62'd0, o_ready, o_valid}, {62'd0, 1'b1, 1'b0});
        @(negedge i_clk);
        i_rst = 1'b0;
        seen_valid = 1'b0;
        for (int k = 0; k < 35; k++) begin
            @(posedge i_clk);
            #1;
            if (o_valid) seen_valid = 1'b1;
        end
        check("mid_reset_no_valid", 64'(seen_valid), 64'd0);
        run_op("after_reset", 32'h40400000, 32'h40000000, 32'h3fc00000, 4'h0, 28, 1'b0);

        for (int n = 0; n < 24; n++) begin
            ra = {1'($urandom), 8'($urandom_range(90, 170)), 23'($urandom)};
            rb = {1'($urandom), 8'($urandom_range(90, 170)), 23'($urandom)};
            run_model("rand_norm", ra, rb);
        end
        for (int n = 0; n < 6; n++) begin
            ra = {1'($urandom), 8'($urandom_range(200, 254)), 23'($urandom)};
            rb = {1'($urandom), 8'($urandom_range(1, 60)), 23'($urandom)};
            run_model("rand_big", ra, rb);
            run_model("rand_small", rb, ra);
        end
        for (int n = 0; n < 6; n++) begin
            ra = $urandom;
            rb = $urandom;
            run_model("rand_any", ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
